// File: rtl/regfile_port_driver_pkg.sv
// Shared types and sizing helpers for the register-file port driver.
package regfile_port_driver_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_WAIT   = 3'd4
  } rfState_t;

  // Counter width able to hold the largest phase length.
  function automatic int phaseWidth(input int setupCyc, input int strobeCyc, input int readWait);
    int maxCyc;
    maxCyc = setupCyc;
    if (strobeCyc > maxCyc) maxCyc = strobeCyc;
    if (readWait > maxCyc) maxCyc = readWait;
    return ($clog2(maxCyc + 1) > 1) ? $clog2(maxCyc + 1) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_driver_if.sv
// Request/response channel between the datapath (master) and the port driver (slave).
interface regfile_port_driver_if
  import regfile_port_driver_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqRs1;
  logic [ADDR_W-1:0] ReqRs2;
  logic [ADDR_W-1:0] ReqRd;
  logic [DATA_W-1:0] ReqWData;
  logic              RspValid;
  logic              RspReady;
  logic [DATA_W-1:0] RspData1;
  logic [DATA_W-1:0] RspData2;
  logic              WrDone;

  modport master (
    output ReqValid, ReqWrite, ReqRs1, ReqRs2, ReqRd, ReqWData, RspReady,
    input  ReqReady, RspValid, RspData1, RspData2, WrDone
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqRs1, ReqRs2, ReqRd, ReqWData, RspReady,
    output ReqReady, RspValid, RspData1, RspData2, WrDone
  );

endinterface

// File: rtl/regfile_phase_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module regfile_phase_timer #(
  parameter int W = 1
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/regfile_port_driver.sv
// Owns the register file write port and both read ports behind a valid/ready request/response pair.
// state    | meaning
// IDLE     | ready for a request unless a read response is still held
// W_SETUP  | write address/data driven, RegWrite low
// W_STROBE | RegWrite high
// W_HOLD   | RegWrite low again, address/data still held
// R_WAIT   | read addresses driven, waiting for the read muxes to settle
module regfile_port_driver
  import regfile_port_driver_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int READ_WAIT  = 1
) (
  input  logic                Clock,
  input  logic                ResetN,
  regfile_port_driver_if.slave bus,
  output logic [ADDR_W-1:0]   WriteRegNum,
  output logic [DATA_W-1:0]   WriteData,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   ReadRegNum1,
  output logic [ADDR_W-1:0]   ReadRegNum2,
  input  logic [DATA_W-1:0]   ReadData1,
  input  logic [DATA_W-1:0]   ReadData2
);

  localparam int PHASE_W = phaseWidth(SETUP_CYC, STROBE_CYC, READ_WAIT);
  localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
  localparam logic [PHASE_W-1:0] STROBE_LD = PHASE_W'(STROBE_CYC - 1);
  localparam logic [PHASE_W-1:0] READ_LD   = PHASE_W'(READ_WAIT - 1);

  rfState_t            state;
  logic                rspValid;
  logic [DATA_W-1:0]   rspData1;
  logic [DATA_W-1:0]   rspData2;
  logic                wrDone;
  logic                reqReady;
  logic                accept;
  logic                timerLoad;
  logic [PHASE_W-1:0]  timerLoadVal;
  logic                timerDone;

  // Gated by ResetN so the requestor sees not-ready while reset is held.
  assign reqReady = ResetN && (state == IDLE) && !rspValid;
  assign accept   = bus.ReqValid && reqReady;

  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          timerLoad    = 1'b1;
          timerLoadVal = bus.ReqWrite ? SETUP_LD : READ_LD;
        end
      end
      W_SETUP: begin
        if (timerDone) begin
          timerLoad    = 1'b1;
          timerLoadVal = STROBE_LD;
        end
      end
      default: ;
    endcase
  end

  regfile_phase_timer #(.W(PHASE_W)) uTimer (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .done    (timerDone)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      WriteRegNum <= '0;
      WriteData   <= '0;
      RegWrite    <= 1'b0;
      ReadRegNum1 <= '0;
      ReadRegNum2 <= '0;
      rspValid    <= 1'b0;
      rspData1    <= '0;
      rspData2    <= '0;
      wrDone      <= 1'b0;
    end else begin
      wrDone <= 1'b0;
      if (rspValid && bus.RspReady) rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.ReqWrite) begin
              WriteRegNum <= bus.ReqRd;
              WriteData   <= bus.ReqWData;
              state       <= W_SETUP;
            end else begin
              ReadRegNum1 <= bus.ReqRs1;
              ReadRegNum2 <= bus.ReqRs2;
              state       <= R_WAIT;
            end
          end
        end
        W_SETUP: begin
          if (timerDone) begin
            RegWrite <= 1'b1;
            state    <= W_STROBE;
          end
        end
        W_STROBE: begin
          if (timerDone) begin
            RegWrite <= 1'b0;
            state    <= W_HOLD;
          end
        end
        W_HOLD: begin
          wrDone <= 1'b1;
          state  <= IDLE;
        end
        R_WAIT: begin
          if (timerDone) begin
            rspData1 <= ReadData1;
            rspData2 <= ReadData2;
            rspValid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          RegWrite <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ReqReady = reqReady;
  assign bus.RspValid = rspValid;
  assign bus.RspData1 = rspData1;
  assign bus.RspData2 = rspData2;
  assign bus.WrDone   = wrDone;

endmodule

// File: doc/regfile_port_driver.md
Name: regfile_port_driver

Overview:
- Initiator that owns the register file's write port and both read ports, and presents a single valid/ready request channel and a valid/ready response channel to the datapath.
- Writes run as a glitch-free setup / strobe / hold sequence on RegWrite, because the register file captures data on the rising edge of its decoded write strobe.
- Reads drive both read addresses, wait a fixed settle time for the tri-state read muxes, then register both read-data buses into a held response.

Parameters:
- DATA_W, 32, data width of WriteData, ReadData1/2, ReqWData and RspData1/2.
- ADDR_W, 5, register-number width.
- SETUP_CYC, 1, cycles WriteRegNum/WriteData are stable before RegWrite rises; must be >=1.
- STROBE_CYC, 1, cycles RegWrite stays high; must be >=1.
- READ_WAIT, 1, cycles from read address drive to data sample; must be >=1.

Ports:
- Clock, in, 1, single clock; all flops rising-edge.
- ResetN, in, 1, asynchronous active-low reset.
- ReqValid, in, 1, request present.
- ReqReady, out, 1, request accepted when ReqValid&&ReqReady at a rising edge.
- ReqWrite, in, 1, 1 = write, 0 = read pair.
- ReqRs1, in, ADDR_W, read register number 1.
- ReqRs2, in, ADDR_W, read register number 2.
- ReqRd, in, ADDR_W, write register number.
- ReqWData, in, DATA_W, write data.
- RspValid, out, 1, read response held.
- RspReady, in, 1, response consumed when RspValid&&RspReady.
- RspData1, out, DATA_W, sampled ReadData1.
- RspData2, out, DATA_W, sampled ReadData2.
- WrDone, out, 1, one-cycle pulse when a write sequence completes.
- WriteRegNum, out, ADDR_W, to register file.
- WriteData, out, DATA_W, to register file.
- RegWrite, out, 1, to register file; driven directly from a flop.
- ReadRegNum1, out, ADDR_W, to register file.
- ReadRegNum2, out, ADDR_W, to register file.
- ReadData1, in, DATA_W, from register file.
- ReadData2, in, DATA_W, from register file.

Behaviour:
- Reset (async, ResetN=0): state IDLE, counter 0. All outputs 0, including RegWrite, RspValid, WrDone, all address/data outputs and ReqReady.
- Reset mid-write: RegWrite falls immediately. If reset hits in W_SETUP, no write occurs.
- ReqReady = (state==IDLE) && !RspValid. It is registered-state based, with no combinational path from ReqValid.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_WAIT.
- Write accepted at edge t: WriteRegNum<=ReqRd and WriteData<=ReqWData; go to W_SETUP.
  - RegWrite rises at edge t+SETUP_CYC (W_STROBE).
  - RegWrite falls at edge t+SETUP_CYC+STROBE_CYC (W_HOLD). Address and data are held through W_HOLD.
  - Next edge: IDLE, with WrDone=1 for one cycle.
  - Defaults: 3 busy cycles; next accept possible at edge t+3.
- WriteRegNum/WriteData change only on write accept. They are held indefinitely otherwise and are never altered while RegWrite=1.
- Read accepted at edge t: ReadRegNum1<=ReqRs1 and ReadRegNum2<=ReqRs2; go to R_WAIT.
  - At edge t+READ_WAIT: RspData1<=ReadData1, RspData2<=ReadData2, RspValid<=1, state IDLE.
  - Values, including x/z, are passed unchanged.
- RspValid with RspData1/2 is held stable until the edge where RspReady=1, then cleared. New requests are blocked while RspValid=1.
- RspReady=1 on the same edge RspValid is first set has no effect; the response persists at least one cycle.
- ReadRegNum1/2 hold their last values between reads.
- Back-to-back ordering: a read after a write always observes the new data, because the write fully completes (W_HOLD) before IDLE.
- Read of a register never written returns whatever the register file drives; no substitution.
- ReqValid with ReqReady=0: ignored. Requestor inputs are don't-care.

Decomposition:
- Package regfile_port_driver_pkg: state enum, default DATA_W/ADDR_W, phase-count width (clog2 of max(SETUP_CYC, STROBE_CYC, READ_WAIT)+1).
- One sub-module, regfile_phase_timer: loadable down-counter with done flag. It is shared by W_SETUP, W_STROBE and R_WAIT and cleared on reset.

Test Plan:
- Write r3 = 32'h0000_0003 with defaults → RegWrite low at the accept edge, high exactly one cycle after, low after; WriteRegNum=3 stable from one cycle before RegWrite rises until after it falls; WrDone pulses once; ReqReady low for 3 cycles.
- Write r1=1 and r2=2, then read (1,2) → RspValid one cycle after the read accept; RspData1=1, RspData2=2.
- Read (4,5) with RspReady held 0 for 5 cycles → RspValid/RspData stable for all 5 cycles; ReqReady=0 throughout; a new ReqValid is ignored; clears on the RspReady edge.
- Write r1=32'h000F_FFFF immediately followed by read (1,0) → RspData1=32'h000F_FFFF.
- Assert ResetN=0 during W_STROBE of a write r6=32'hDEAD_BEEF → RegWrite drops with no clock; all outputs 0; after release, ReqReady=1 on the first cycle.
- SETUP_CYC=2, STROBE_CYC=3, READ_WAIT=2 → RegWrite rises at edge t+2 and falls at t+5; read sample occurs at edge t+2.
